// File: rtl/count_sequencer_if.sv
// Host-side control interface of count_sequencer.
// Carries the start/busy/done handshake, the run configuration, pause/abort
// and the completed-epoch count.
//   master : host / supervisor (drives start, cfg_*, pause, abort)
//   slave  : count_sequencer   (drives busy, done, epoch_cnt)
interface count_sequencer_if #(
  parameter int EPOCH_W = 8,
  parameter int DIV_W   = 4
);
  logic               start;
  logic [EPOCH_W-1:0] cfg_epochs;
  logic [DIV_W-1:0]   cfg_div;
  logic               pause;
  logic               abort;
  logic               busy;
  logic               done;
  logic [EPOCH_W-1:0] epoch_cnt;

  modport master (
    output start, cfg_epochs, cfg_div, pause, abort,
    input  busy, done, epoch_cnt
  );

  modport slave (
    input  start, cfg_epochs, cfg_div, pause, abort,
    output busy, done, epoch_cnt
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer for a 4-bit enable/carry ripple counter that has no reset.
// Aligns the counter to zero (SYNC), then runs a programmed number of full
// 16-count epochs, issuing one count enable every cfg_div+1 unpaused cycles.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   host      : control interface (start/cfg/pause/abort in, busy/done/epoch_cnt out)
//   cnt_en    : counter enable (carry-chain input)
//   cnt_carry : counter carry-out, combinational from cnt_en
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counter held (cnt_en = 0)
// SYNC  | counting until the counter wraps, aligning it to zero
// RUN   | prescaled counting; one epoch per counter wrap
// DONE  | single-cycle completion pulse, then back to IDLE
module count_sequencer #(
  parameter int EPOCH_W = 8,
  parameter int DIV_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  count_sequencer_if.slave    host,
  output logic                cnt_en,
  input  logic                cnt_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
  localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);

  state_t             state_q, state_d;
  logic [EPOCH_W-1:0] epochs_l;
  logic [DIV_W-1:0]   div_l;
  logic [DIV_W-1:0]   div_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [EPOCH_W-1:0] epoch_inc;
  logic               accept;
  logic               wrap;
  logic               busy_o;
  logic               done_o;

  assign accept    = (state_q == S_IDLE) && host.start && !host.abort;
  // cnt_en is already forced low in IDLE/DONE and on abort, so a carry seen
  // outside a real enable cycle never counts.
  assign wrap      = cnt_en && cnt_carry;
  assign epoch_inc = epoch_q + EPOCH_ONE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_SYNC;
      S_SYNC: begin
        if (host.abort)  state_d = S_IDLE;
        else if (wrap)   state_d = (epochs_l == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (host.abort)                          state_d = S_IDLE;
        else if (wrap && (epoch_inc == epochs_l)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cnt_en = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_SYNC: begin
        busy_o = 1'b1;
        cnt_en = !host.pause && !host.abort;
      end
      S_RUN: begin
        busy_o = 1'b1;
        cnt_en = !host.pause && !host.abort && (div_q == div_l);
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = !host.abort;
      end
      default: ;
    endcase
  end

  // Latched configuration, prescaler and epoch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epochs_l <= '0;
      div_l    <= '0;
      div_q    <= '0;
      epoch_q  <= '0;
    end else if (accept) begin
      epochs_l <= host.cfg_epochs;
      div_l    <= host.cfg_div;
      div_q    <= '0;
      epoch_q  <= '0;
    end else if (state_q == S_RUN && !host.abort) begin
      if (cnt_en)           div_q <= '0;
      else if (!host.pause) div_q <= div_q + DIV_ONE;
      if (wrap)             epoch_q <= epoch_inc;
    end
  end

  assign host.busy      = busy_o;
  assign host.done      = done_o;
  assign host.epoch_cnt = epoch_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural 4-bit counter without reset, a
// scoreboard of expected run endings, and a monitor that scores each ending.
module tb_count_sequencer;

  logic clk;
  logic rst_n;
  logic cnt_en;
  logic cnt_carry;

  count_sequencer_if #(.EPOCH_W(8), .DIV_W(4)) hif ();

  count_sequencer #(.EPOCH_W(8), .DIV_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (hif),
    .cnt_en    (cnt_en),
    .cnt_carry (cnt_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter model: no reset, preset port for test setup only
  logic [3:0] cnt_q;
  logic       preset_req;
  logic [3:0] preset_val;
  always @(posedge clk) begin
    if (preset_req)  cnt_q <= preset_val;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end
  assign cnt_carry = cnt_en && (cnt_q == 4'hF);

  typedef struct {
    bit is_done;
    int epoch;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   busy_prev = 1'b0;
  bit   done_prev = 1'b0;
  int   busy_len  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void expect_end(bit d, int ep, int len);
    exp_t e;
    e.is_done = d;
    e.epoch   = ep;
    e.len     = len;
    sb.push_back(e);
  endfunction

  task automatic score_end(bit d);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected actual_done=%0d required=no_event", d);
    end else begin
      e = sb.pop_front();
      check("end_kind", 32'(d), 32'(e.is_done));
      check("end_epoch", 32'(hif.epoch_cnt), e.epoch);
      if (e.is_done) check("run_len", busy_len, e.len);
    end
  endtask

  // monitor: one scoreboard entry per run ending (done pulse or busy drop)
  always @(negedge clk) begin
    if (hif.busy === 1'b1 && !busy_prev) busy_len = 1;
    else if (hif.busy === 1'b1)          busy_len++;
    if (hif.done === 1'b1)                                   score_end(1'b1);
    else if (busy_prev && hif.busy !== 1'b1 && !done_prev)   score_end(1'b0);
    busy_prev = (hif.busy === 1'b1);
    done_prev = (hif.done === 1'b1);
  end

  task automatic preset(logic [3:0] v);
    preset_val = v;
    preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
  endtask

  task automatic do_start(int ep, int dv);
    hif.cfg_epochs = 8'(ep);
    hif.cfg_div    = 4'(dv);
    hif.start      = 1'b1;
    @(posedge clk); #1;
    hif.start      = 1'b0;
  endtask

  task automatic wait_idle(string name, int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (hif.busy === 1'b0) seen = 1'b1;
    end
    check({"timeout_", name}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    hif.start      = 1'b0;
    hif.cfg_epochs = '0;
    hif.cfg_div    = '0;
    hif.pause      = 1'b0;
    hif.abort      = 1'b0;
    preset_req     = 1'b0;
    preset_val     = 4'd0;

    repeat (2) @(negedge clk);
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_busy", 32'(hif.busy), 0);
    check("rst_done", 32'(hif.done), 0);
    check("rst_epoch", 32'(hif.epoch_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: counter at 13 -> SYNC 3, RUN 16, DONE 1
    preset(4'd13);
    expect_end(1, 1, 20);
    do_start(1, 0);
    wait_idle("t1", 60);

    // 2: counter at 15, 3 epochs, div 2 -> SYNC 1, RUN 144, DONE 1
    preset(4'd15);
    expect_end(1, 3, 146);
    do_start(3, 2);
    wait_idle("t2", 300);

    // 3: zero target, counter at 0 -> SYNC 16 then DONE
    preset(4'd0);
    expect_end(1, 0, 17);
    do_start(0, 0);
    wait_idle("t3", 60);

    // 4a: div 1 unpaused -> SYNC 1, RUN 32, DONE 1
    preset(4'd15);
    expect_end(1, 1, 34);
    do_start(1, 1);
    wait_idle("t4a", 80);

    // 4b: same with 5 paused cycles mid-RUN -> 5 cycles longer
    preset(4'd15);
    expect_end(1, 1, 39);
    do_start(1, 1);
    repeat (8) @(posedge clk);
    #1 hif.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_cnt_en", 32'(cnt_en), 0);
    end
    @(posedge clk); #1;
    hif.pause = 1'b0;
    wait_idle("t4b", 80);

    // 5: abort in RUN after first of two epochs, with start alongside
    preset(4'd15);
    expect_end(0, 1, 0);
    do_start(2, 0);
    repeat (20) @(posedge clk);
    #1;
    hif.abort = 1'b1;
    hif.start = 1'b1;
    @(negedge clk);
    check("abort_cnt_en", 32'(cnt_en), 0);
    @(posedge clk); #1;
    hif.abort = 1'b0;
    hif.start = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(hif.busy), 0);
    @(negedge clk);
    check("abort_no_restart", 32'(hif.busy), 0);
    @(posedge clk); #1;

    // start together with abort in IDLE is rejected
    hif.start = 1'b1;
    hif.abort = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    hif.abort = 1'b0;
    @(negedge clk);
    check("idle_abort_start", 32'(hif.busy), 0);
    @(posedge clk); #1;

    // 6: start held through a run; second run taken from the IDLE gap
    preset(4'd14);
    expect_end(1, 1, 19);
    expect_end(1, 1, 33);
    hif.cfg_epochs = 8'd1;
    hif.cfg_div    = 4'd0;
    hif.start      = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (hif.done === 1'b1) seen = 1'b1;
      end
      check("timeout_t6_done", 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("held_start_gap", 32'(hif.busy), 0);
    @(posedge clk); #1;
    hif.start = 1'b0;
    wait_idle("t6", 80);

    // 7: asynchronous reset mid-RUN clears outputs without a clock edge
    preset(4'd15);
    expect_end(0, 0, 0);
    do_start(2, 0);
    repeat (20) @(posedge clk);
    #3;
    check("pre_rst_epoch", 32'(hif.epoch_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("arst_cnt_en", 32'(cnt_en), 0);
    check("arst_busy", 32'(hif.busy), 0);
    check("arst_done", 32'(hif.done), 0);
    check("arst_epoch", 32'(hif.epoch_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller for the 4-bit enable/carry ripple counter (XOR/AND/dff chain).
- Drives the counter's count-enable input, observes its carry-out, and runs a programmed number of full 16-count epochs at a programmable rate.
- Has a start/busy/done handshake, plus pause and abort.
- The counter has no reset, so the sequencer first aligns it to zero (SYNC) before counting epochs.

Parameters:
- EPOCH_W, 8, width of the epoch target and epoch count.
- DIV_W, 4, width of the prescaler divide value.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- cfg_epochs  input  EPOCH_W  epochs to run; latched on accepted start.
- cfg_div  input  DIV_W  enable issued every cfg_div+1 RUN cycles; latched on accepted start.
- pause  input  1  level; stalls SYNC/RUN while high.
- abort  input  1  pulse or level; returns to IDLE.
- cnt_en  output  1  drives counter enable (counter carry-chain input).
- cnt_carry  input  1  counter carry-out (enable AND all four bits set; combinational from cnt_en).
- busy  output  1  high in SYNC, RUN, DONE.
- done  output  1  one-cycle pulse on successful completion.
- epoch_cnt  output  EPOCH_W  epochs completed in current/last run.

Behaviour:
- Reset (rst_n low, asynchronous) -> state IDLE; cnt_en=0, busy=0, done=0, epoch_cnt=0; prescaler and latched config cleared. Reset mid-run abandons the run; counter contents are not touched.
- States: IDLE, SYNC, RUN, DONE; 2-bit encoded, registered.
- cnt_en is combinational from state/prescaler/pause and never asserts in IDLE or DONE.
- IDLE
  - start=1 and abort=0 -> latch cfg_epochs and cfg_div, clear epoch_cnt and prescaler, go to SYNC next cycle.
  - abort has priority over start.
  - start in any other state is ignored; no queueing.
- SYNC
  - cnt_en = !pause.
  - cnt_en and cnt_carry in the same cycle -> counter wraps to 0.
    - Target 0 -> DONE next cycle.
    - Otherwise -> RUN next cycle.
  - Takes 1 to 16 unpaused cycles, depending on the counter's unknown start value.
- RUN
  - Prescaler div_q counts 0..div_l. cnt_en = !pause and (div_q == div_l).
  - On cnt_en, div_q -> 0. Otherwise, if !pause, div_q increments.
  - While pause is high, div_q holds.
  - On cnt_en and cnt_carry, epoch_cnt increments (wraps modulo 2^EPOCH_W; unreachable because target < 2^EPOCH_W).
  - If epoch_cnt+1 == target -> DONE next cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. epoch_cnt holds its final value until the next accepted start.
- abort=1 in SYNC, RUN or DONE -> IDLE next cycle, no done pulse, epoch_cnt holds. In the abort cycle cnt_en is forced to 0. abort in IDLE has no effect.
- cnt_carry while cnt_en=0 is ignored (cannot occur with a correct counter). cnt_carry is ignored in IDLE/DONE.
- With cfg_div=0 the counter advances every unpaused RUN cycle.
- One epoch = 16·(div+1) unpaused RUN cycles.

Test Plan:
- Reset with counter preset to 13; start with cfg_epochs=1, cfg_div=0 -> SYNC for 3 cycles (carry on 3rd), RUN for 16 cycles with carry on the 16th, done pulses 1 cycle later, epoch_cnt=1, busy low the cycle after done.
- cfg_epochs=3, cfg_div=2, counter starting at 15 -> SYNC 1 cycle; cnt_en every 3rd RUN cycle; done after 144 RUN cycles; epoch_cnt=3.
- cfg_epochs=0, counter at 0 -> SYNC runs 16 cycles, then DONE directly; epoch_cnt=0; no RUN cycles.
- Pause held 5 cycles mid-RUN with cfg_div=1 -> cnt_en low and prescaler frozen during pause; done delayed by exactly 5 cycles versus the unpaused run.
- abort during RUN after 1 of 2 epochs -> cnt_en low in the abort cycle, IDLE next cycle, no done, epoch_cnt=1. A start asserted together with the abort is not accepted.
- start held high through a whole run, and start asserted during RUN -> only the IDLE-sampled start is accepted; a second run begins the cycle after done.
- rst_n asserted asynchronously mid-RUN -> all outputs 0 immediately, with no clock edge needed.
